data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the datapath's load/store port.
//  Serves MemRead/MemWrite requests issued with ALUOut as address and WriteData as store data.
//  Returns ReadData after a configurable number of wait states.
//  Holds Stall high until each access completes; the core gates its PC/register-file update with Stall.
// PARAMETERS
//  ADDR_W   6  word-address width; memory holds 2**ADDR_W 32-bit words
//  WAIT     2  wait states inserted per access (0..15)
// PORTS
//  CLK       in   1   clock, all state updates on rising edge
//  RST       in   1   synchronous, active-high reset
//  MemRead   in   1   load request, level, held by core while Stall=1
//  MemWrite  in   1   store request, level, held by core while Stall=1
//  A         in   32  byte address (core ALUOut)
//  WD        in   32  store data (core WriteData)
//  RD        out  32  load data (core ReadData), registered
//  Stall     out  1   1 = access in progress, core must freeze
//  MemErr    out  1   1 = faulted access (ALIGN_CHECK_EN only)
// BEHAVIOUR
//  Interface timing
//  - One clock (CLK). Reset is synchronous and active-high (RST).
//  Reset
//  - state=IDLE, counter=0, RD=0, MemErr=0, all memory words=0.
//  - RST asserted mid-access aborts it; the pending write is not committed.
//  Request decoding
//  - req = MemRead|MemWrite.
//  - Both high: the access is a write. RD is not updated.
//  - Word index = A[ADDR_W+1:2]. A[1:0] is ignored. Upper bits alias (no macro).
//  FSM
//  - IDLE: req=1 -> latch A, WD, op, and load cnt=WAIT.
//    - WAIT=0: go to DONE. Otherwise go to BUSY.
//  - BUSY: req=0 -> IDLE (abort, no write). Else cnt==1 -> DONE. Else cnt-=1.
//  - DONE: exactly one cycle, then always IDLE.
//    - Write: mem[idx]<=WD_latched on the DONE->IDLE edge.
//    - Read: RD<=mem[idx] on the edge entering DONE, so RD is valid throughout DONE and held after.
//  Stall
//  - Stall = req & (state!=DONE), combinational.
//  - The access occupies WAIT+2 cycles. Stall is high for the first WAIT+1 of them.
//  - Stall is low in DONE, so the core advances on the DONE edge.
//  Latched operands
//  - A/WD changes during BUSY are ignored; the latched values are used.
//  Back-to-back accesses
//  - A new req seen in IDLE the cycle after DONE starts a new access.
//  - The earlier write is already committed, so read-after-write returns the new data.
//  Misc
//  - RD holds its last load value between accesses. MemErr=0 outside DONE.
// CONFIGURATION
//  Macro: ALIGN_CHECK_EN
//  - Defined: an access faults if A[1:0]!=0 or A[31:ADDR_W+2]!=0.
//    - A faulted access still runs the full FSM timing.
//    - It performs no write.
//    - On read, RD<=32'h0000_0000.
//    - MemErr=1 during its DONE cycle only.
//  - Undefined: MemErr tied 0, no address checks, aliasing as above.
// TESTING
//  1. RST=1 for 2 cycles.
//     -> RD=0, Stall=0, MemErr=0. Read of word 5 returns 0.
//  2. WAIT=2: MemWrite, A=0x14, WD=0xCAFEF00D. Then MemRead, A=0x14.
//     -> Stall high 3 cycles per access. RD=0xCAFEF00D in read's DONE cycle.
//  3. Drop MemWrite during BUSY (A=0x8, WD=0x1234).
//     -> FSM returns to IDLE. A later read of 0x8 returns 0.
//  4. WAIT=0: back-to-back write 0x20=0xA5A5A5A5, then read 0x20.
//     -> Each access stalls 1 cycle. RD=0xA5A5A5A5.
//  5. RST asserted in BUSY of a write to 0x4.
//     -> IDLE next cycle. Stall=0. Word 1 reads back 0.
//  6. ALIGN_CHECK_EN defined: read A=0x6, then write A=0x400.
//     -> MemErr=1 in each DONE, RD=0 after the read, memory unchanged.
//     Undefined: A=0x6 reads word 1.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store memory responder with a fixed number of wait states per access.
// Optional build macro ALIGN_CHECK_EN: misaligned or out-of-range accesses fault.
module data_mem_responder #(
  parameter int ADDR_W = 6,
  parameter int WAIT   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        MemErr
);

  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wd_q, wd_d;
  logic                wr_q, wr_d;
  logic                fault_q, fault_d;
  logic [31:0]         rd_q, rd_d;
  logic [31:0]         mem_q [DEPTH];
  logic                mem_we;

  logic                req;
  logic [ADDR_W-1:0]   a_idx;
  logic                a_fault;

  assign req   = MemRead | MemWrite;
  assign a_idx = A[ADDR_W+1:2];

`ifdef ALIGN_CHECK_EN
  assign a_fault = (A[1:0] != 2'b00) || (A[31:ADDR_W+2] != '0);
`else
  // Byte-offset and upper address bits are don't-care: upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{A[31:ADDR_W+2], A[1:0]};
  assign a_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    rd_d    = rd_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = a_idx;
          wd_d    = WD;
          wr_d    = MemWrite;
          fault_d = a_fault;
          cnt_d   = WAIT_L;
          if (WAIT_L == 4'd0) begin
            state_d = DONE;
            // With no wait states the load is captured straight from the live address.
            if (!MemWrite) rd_d = a_fault ? 32'h0 : mem_q[a_idx];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!wr_q) rd_d = fault_q ? 32'h0 : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        mem_we  = wr_q & ~fault_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= 32'h0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
      if (mem_we) mem_q[idx_q] <= wd_q;
    end
  end

  // Operand latches carry data only and need no reset.
  always_ff @(posedge CLK) begin
    idx_q <= idx_d;
    wd_q  <= wd_d;
  end

  assign RD     = rd_q;
  assign Stall  = req & (state_q != DONE);
  assign MemErr = (state_q == DONE) & fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT=2, one with WAIT=0.
// Directed table, hand sequences for abort/reset, then randomized accesses vs a model.
module tb_data_mem_responder;

  localparam int ADDR_W = 6;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [31:0] ad [2];
  logic [31:0] wdat [2];
  logic [31:0] rd [2];
  logic        stall [2];
  logic        err [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT(W0)) dut0 (
    .CLK(clk), .RST(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .A(ad[0]), .WD(wdat[0]),
    .RD(rd[0]), .Stall(stall[0]), .MemErr(err[0]));

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT(W1)) dut1 (
    .CLK(clk), .RST(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .A(ad[1]), .WD(wdat[1]),
    .RD(rd[1]), .Stall(stall[1]), .MemErr(err[1]));

  int errors = 0;
  int checks = 0;

  logic [31:0] mm  [2][64];
  logic [31:0] rdm [2];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic bit mfault(input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
    return (a % 4 != 0) || (a >= (32'd1 << (ADDR_W + 2)));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int midx(input logic [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  task automatic model_step(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] er, output bit ee);
    bit f;
    f = mfault(a);
    if (wr) begin
      er = rdm[d];
      if (!f) mm[d][midx(a)] = wd;
    end else begin
      er = f ? 32'h0 : mm[d][midx(a)];
      rdm[d] = er;
    end
    ee = f;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mm[0][i] = 32'h0;
      mm[1][i] = 32'h0;
    end
    rdm[0] = 32'h0;
    rdm[1] = 32'h0;
  endtask

  // One access; leaves the request asserted so a following call is back-to-back.
  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input string nm);
    int n;
    n = 0;
    @(posedge clk); #1;
    mw[d] = wr;
    mr[d] = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    ad[d] = a;
    wdat[d] = wd;
    @(negedge clk);
    while (stall[d] && n < 40) begin
      n++;
      if (n == 1) chk({nm, "_err_busy"}, 32'(err[d]), 32'h0);
      if (n >= 2) begin
        ad[d] = $urandom;
        wdat[d] = $urandom;
      end
      @(negedge clk);
    end
    chk({nm, "_stall_cycles"}, n, (d == 0) ? W0 + 1 : W1 + 1);
    chk({nm, "_rd"}, rd[d], exp_rd);
    chk({nm, "_memerr"}, 32'(err[d]), 32'(exp_err));
  endtask

  task automatic idle(input int d, input logic [31:0] exp_rd, input string nm);
    @(posedge clk); #1;
    mr[d] = 1'b0;
    mw[d] = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_stall"}, 32'(stall[d]), 32'h0);
    chk({nm, "_idle_err"}, 32'(err[d]), 32'h0);
    chk({nm, "_idle_rd"}, rd[d], exp_rd);
  endtask

  initial begin
    logic [31:0] er;
    bit          ee;
    logic [31:0] a;
    int          d;
    bit          wr;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 32'h0; wdat[k] = 32'h0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d_rd", k), rd[k], 32'h0);
      chk($sformatf("reset%0d_stall", k), 32'(stall[k]), 32'h0);
      chk($sformatf("reset%0d_err", k), 32'(err[k]), 32'h0);
    end

    tbl[0] = '{0, 1'b0, 32'h14,  32'h0,        32'h0,        1'b0};
    tbl[1] = '{0, 1'b1, 32'h14,  32'hCAFEF00D, 32'h0,        1'b0};
    tbl[2] = '{0, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 1'b0};
    tbl[3] = '{1, 1'b1, 32'h20,  32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[4] = '{1, 1'b0, 32'h20,  32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[5] = '{0, 1'b1, 32'h4,   32'h11112222, 32'hCAFEF00D, 1'b0};
`ifdef ALIGN_CHECK_EN
    tbl[6] = '{0, 1'b0, 32'h6,   32'h0,        32'h0,        1'b1};
    tbl[7] = '{0, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0,        1'b1};
    tbl[8] = '{0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
`else
    tbl[6] = '{0, 1'b0, 32'h6,   32'h0,        32'h11112222, 1'b0};
    tbl[7] = '{0, 1'b1, 32'h400, 32'hDEADBEEF, 32'h11112222, 1'b0};
    tbl[8] = '{0, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0};
`endif
    tbl[9] = '{0, 1'b0, 32'h4,   32'h0,        32'h11112222, 1'b0};

    for (int i = 0; i < 10; i++) begin
      if (i > 0 && tbl[i].d != tbl[i-1].d) idle(tbl[i-1].d, rdm[tbl[i-1].d], $sformatf("tbl%0d", i));
      model_step(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, er, ee);
      access(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err,
             $sformatf("tbl%0d", i));
    end
    idle(0, rdm[0], "tbl_end");

    // Abort: write dropped while BUSY must not commit.
    @(posedge clk); #1;
    mw[0] = 1'b1; mr[0] = 1'b0; ad[0] = 32'h8; wdat[0] = 32'h1234;
    @(negedge clk);
    @(posedge clk); #1;
    mw[0] = 1'b0;
    @(negedge clk);
    chk("abort_stall", 32'(stall[0]), 32'h0);
    model_step(0, 1'b0, 32'h8, 32'h0, er, ee);
    access(0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, "abort_read");
    idle(0, 32'h0, "abort_read");

    // Reset in the middle of a write.
    @(posedge clk); #1;
    mw[0] = 1'b1; mr[0] = 1'b0; ad[0] = 32'h4; wdat[0] = 32'h5555AAAA;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mw[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstmid_stall", 32'(stall[0]), 32'h0);
    chk("rstmid_rd", rd[0], 32'h0);
    chk("rstmid_err", 32'(err[0]), 32'h0);
    access(0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, "rstmid_read");
    idle(0, 32'h0, "rstmid_read");

    // Randomized accesses against the model.
    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) * 4;
`ifdef ALIGN_CHECK_EN
      case ($urandom_range(0, 5))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | ($urandom << (ADDR_W + 2));
        default: ;
      endcase
`else
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = a | ($urandom & 32'hFFFF_FF03) & ~32'h0000_00FC;
`endif
      if (mr[1 - d] || mw[1 - d]) idle(1 - d, rdm[1 - d], $sformatf("rnd%0d_other", i));
      model_step(d, wr, a, $urandom, er, ee);
      access(d, wr, a, wr ? mm[d][midx(a)] : 32'h0, er, ee, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle(d, rdm[d], $sformatf("rnd%0d", i));
    end
    idle(0, rdm[0], "final0");
    idle(1, rdm[1], "final1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
